// File: rtl/cff_pipe.sv
// WIDTH x DEPTH register pipeline with complementary outputs, mode-selected hold/shift/clear/rotate, valid tags and occupancy count.
// Latency DEPTH SHIFT edges d->q; no backpressure (full pipe under SHIFT drops the oldest word).
module cff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             q_valid,
    output logic [CW-1:0]    count
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b10;
    localparam logic [1:0] MODE_ROTATE = 2'b11;

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            v_q, v_d;
    logic [CW-1:0]               count_q, count_d;

    always_comb begin
        data_d  = data_q;
        v_d     = v_q;
        count_d = count_q;
        case (mode)
            MODE_SHIFT: begin
                data_d[0] = d;
                v_d[0]    = d_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    data_d[i] = data_q[i-1];
                    v_d[i]    = v_q[i-1];
                end
                // A word entering while another leaves nets to zero change.
                count_d = count_q + CW'(d_valid) - CW'(v_q[DEPTH-1]);
            end
            MODE_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    data_d[i] = RESET_VAL;
                end
                v_d     = '0;
                count_d = '0;
            end
            MODE_ROTATE: begin
                data_d[0] = data_q[DEPTH-1];
                v_d[0]    = v_q[DEPTH-1];
                for (int i = 1; i < DEPTH; i++) begin
                    data_d[i] = data_q[i-1];
                    v_d[i]    = v_q[i-1];
                end
            end
            MODE_HOLD: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            v_q     <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    assign q       = data_q[DEPTH-1];
    assign qbar    = ~data_q[DEPTH-1];
    assign q_valid = v_q[DEPTH-1];
    assign count   = count_q;

endmodule

// File: tb/tb_cff_pipe.sv
// Directed bench for cff_pipe: an 8x4 instance with RESET_VAL=A5 and a 1x1 instance acting as a plain flip-flop.
module tb_cff_pipe;

    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] SHIFT  = 2'b01;
    localparam logic [1:0] CLEAR  = 2'b10;
    localparam logic [1:0] ROTATE = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] d;
    logic       d_valid;
    logic [7:0] q, qbar;
    logic       q_valid;
    logic [2:0] count;

    logic [1:0] mode1;
    logic [0:0] d1;
    logic       dv1;
    logic [0:0] q1, qbar1;
    logic       qv1;
    logic [0:0] count1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .d(d), .d_valid(d_valid),
        .q(q), .qbar(qbar), .q_valid(q_valid), .count(count)
    );

    cff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode1), .d(d1), .d_valid(dv1),
        .q(q1), .qbar(qbar1), .q_valid(qv1), .count(count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_in(input logic [7:0] val, input logic vld);
        mode    = SHIFT;
        d       = val;
        d_valid = vld;
        tick();
    endtask

    logic [7:0] rot_exp [4];

    initial begin
        rot_exp[0] = 8'h02; rot_exp[1] = 8'h03; rot_exp[2] = 8'h04; rot_exp[3] = 8'h01;
        rst_n = 1'b0; mode = HOLD; d = '0; d_valid = 1'b0;
        mode1 = HOLD; d1 = '0; dv1 = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        // 1: asynchronous reset mid-cycle, no clock edge needed
        shift_in(8'h77, 1'b1);
        check("pre_reset_count", 32'(count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", 32'(q), 32'hA5);
        check("rst_qbar", 32'(qbar), 32'h5A);
        check("rst_qv", 32'(q_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        mode = HOLD;
        tick();
        rst_n = 1'b1;

        // 2: fill, latency of DEPTH edges, then overflow drops the oldest
        shift_in(8'h11, 1'b1);
        shift_in(8'h22, 1'b1);
        shift_in(8'h33, 1'b1);
        check("lat3_q", 32'(q), 32'hA5);
        check("lat3_qv", 32'(q_valid), 32'd0);
        shift_in(8'h44, 1'b1);
        check("fill_q", 32'(q), 32'h11);
        check("fill_qbar", 32'(qbar), 32'hEE);
        check("fill_qv", 32'(q_valid), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        shift_in(8'h55, 1'b1);
        check("full_q", 32'(q), 32'h22);
        check("full_count", 32'(count), 32'd4);

        // 3: HOLD stalls, ignoring d; then a bubble enters
        mode = HOLD; d = 8'h99; d_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q", 32'(q), 32'h22);
            check("hold_count", 32'(count), 32'd4);
        end
        shift_in(8'h00, 1'b0);
        check("bubble_q", 32'(q), 32'h33);
        check("bubble_count", 32'(count), 32'd3);

        // 4: load 01..04 then rotate with d toggling
        for (int i = 1; i <= 4; i++) shift_in(8'(i), 1'b1);
        check("rotload_q", 32'(q), 32'h01);
        check("rotload_count", 32'(count), 32'd4);
        mode = ROTATE;
        for (int i = 0; i < 4; i++) begin
            d = (i % 2 == 0) ? 8'hFF : 8'h00;
            d_valid = (i % 2 == 0);
            tick();
            check("rot_q", 32'(q), 32'(rot_exp[i]));
            check("rot_count", 32'(count), 32'd4);
        end

        // 5: clear, bubbles through empty pipe, then reset during SHIFT
        mode = CLEAR; tick();
        shift_in(8'hAA, 1'b1);
        shift_in(8'hBB, 1'b1);
        check("two_count", 32'(count), 32'd2);
        mode = CLEAR; tick();
        check("clr_q", 32'(q), 32'hA5);
        check("clr_qv", 32'(q_valid), 32'd0);
        check("clr_count", 32'(count), 32'd0);
        shift_in(8'h12, 1'b0);
        check("empty_count", 32'(count), 32'd0);
        shift_in(8'hC1, 1'b1);
        shift_in(8'hC2, 1'b1);
        shift_in(8'hC3, 1'b1);
        shift_in(8'hC4, 1'b1);
        check("pre_rst2_q", 32'(q), 32'hC1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_q", 32'(q), 32'hA5);
        check("rst2_qv", 32'(q_valid), 32'd0);
        check("rst2_count", 32'(count), 32'd0);
        tick();
        check("rst2_hold_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        shift_in(8'hD1, 1'b1);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_q", 32'(q), 32'hA5);

        // 6: DEPTH=1, WIDTH=1 flip-flop behaviour
        mode = HOLD;
        check("ff_rst_q", 32'(q1), 32'd0);
        check("ff_rst_qbar", 32'(qbar1), 32'd1);
        mode1 = SHIFT; d1 = 1'b1; dv1 = 1'b1; tick();
        check("ff_q1", 32'(q1), 32'd1);
        check("ff_qbar1", 32'(qbar1), 32'd0);
        check("ff_count1", 32'(count1), 32'd1);
        mode1 = ROTATE; d1 = 1'b0; tick();
        check("ff_rot_q", 32'(q1), 32'd1);
        mode1 = HOLD; tick();
        check("ff_hold_q", 32'(q1), 32'd1);
        mode1 = SHIFT; d1 = 1'b0; dv1 = 1'b1; tick();
        check("ff_q0", 32'(q1), 32'd0);
        check("ff_qbar0", 32'(qbar1), 32'd1);
        check("ff_swap_count", 32'(count1), 32'd1);
        dv1 = 1'b0; tick();
        check("ff_empty_count", 32'(count1), 32'd0);
        check("ff_empty_qv", 32'(qv1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cff_pipe.md
Name: cff_pipe

Overview:
- Parametrised multi-bit, multi-stage flip-flop pipeline with complementary outputs.
- Generalises the single-bit q/qbar CMOS flip-flop cell to WIDTH bits by DEPTH stages.
- Adds mode-selected hold, shift, clear and rotate operations, per-stage valid tracking and an occupancy count.
- Used as a delay line or recirculating buffer between switch-level cells and behavioural stimulus blocks.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of pipeline stages (>=1).
- RESET_VAL, 0, WIDTH-bit value loaded into every stage on reset or clear.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  operation select: 00 HOLD, 01 SHIFT, 10 CLEAR, 11 ROTATE.
- d  input  WIDTH  data into stage 0 (SHIFT only).
- d_valid  input  1  valid tag for d (SHIFT only).
- q  output  WIDTH  contents of stage DEPTH-1.
- qbar  output  WIDTH  bitwise complement of q.
- q_valid  output  1  valid tag of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of stages holding valid data.

Behaviour:
- Clocking and reset: one clock (clk, rising edge); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, any time including mid-operation):
  - all stages = RESET_VAL; all valid bits = 0; count = 0.
  - q = RESET_VAL; qbar = ~RESET_VAL; q_valid = 0.
  - Takes effect immediately, without waiting for a clk edge.
  - The first rising edge with rst_n=1 executes the current mode normally.
- State per stage i (0..DEPTH-1): data[i] (WIDTH bits) and v[i] (1 bit).
- All updates occur on the rising clk edge and are evaluated per mode:
  - HOLD (00): no state change; d and d_valid are ignored.
  - SHIFT (01): data[0]<=d, v[0]<=d_valid; data[i]<=data[i-1], v[i]<=v[i-1] for i>=1. The stage DEPTH-1 contents are discarded.
  - CLEAR (10): every data[i]<=RESET_VAL, every v[i]<=0, count<=0. Synchronous counterpart of reset.
  - ROTATE (11): data[0]<=data[DEPTH-1], v[0]<=v[DEPTH-1]; other stages shift as in SHIFT; d and d_valid are ignored.
- Outputs:
  - q = data[DEPTH-1] and q_valid = v[DEPTH-1], driven directly from registers with no combinational path from d.
  - qbar = ~q at all times; q and qbar are never equal on any bit once out of reset.
- Latency: a word accepted in SHIFT appears on q after exactly DEPTH SHIFT edges. HOLD cycles stall the pipeline without loss.
- count update:
  - SHIFT: count <= count + d_valid - v[DEPTH-1]. Simultaneous entry and exit of a valid word leaves count unchanged.
  - CLEAR: count <= 0.
  - HOLD and ROTATE: count unchanged.
  - count must always equal the popcount of v[] and stay within 0..DEPTH.
- Boundaries:
  - Full pipe (count=DEPTH) under SHIFT with d_valid=1: oldest word drops off, count stays DEPTH. No overflow flag.
  - Empty pipe under SHIFT with d_valid=0: data still shifts (bubbles move), count stays 0.
  - DEPTH=1: SHIFT loads the single stage; ROTATE equals HOLD.
  - WIDTH=1 must behave as a plain q/qbar flip-flop with a hold mode.

Test Plan:
1. Reset with WIDTH=8, DEPTH=4, RESET_VAL=8'hA5: assert rst_n=0 mid-cycle -> q=8'hA5, qbar=8'h5A, q_valid=0, count=0 immediately, with no clk edge.
2. SHIFT d=8'h11,8'h22,8'h33,8'h44 with d_valid=1 -> q=8'h11 after edge 4, q_valid=1, count=4; fifth SHIFT with d=8'h55 -> q=8'h22, count=4.
3. From the full state in scenario 2, apply 3 HOLD edges -> q stays 8'h22, count=4; then 1 SHIFT with d_valid=0 -> q=8'h33, count=3.
4. Load 8'h01..8'h04, then 4 ROTATE edges -> q sequence 8'h02,8'h03,8'h04,8'h01, count constant at 4, d toggling ignored.
5. Load 2 valid words, then CLEAR -> next edge q=RESET_VAL, q_valid=0, count=0. Then deassert/assert rst_n during SHIFT -> state resets asynchronously.
6. DEPTH=1, WIDTH=1: SHIFT d=1 -> q=1, qbar=0 after 1 edge; ROTATE and HOLD keep q=1; d=0 with SHIFT -> q=0, qbar=1.
